// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pkg
//  Description : Shared motor-control definitions. Holds the direction
//                encodings used by the IR-sensor direction sequencer and the
//                step pulse generator, the pulse-generator state type and a
//                helper that classifies motion states.
//  Contents    : FW / BW      direction encodings (1 = forward, 0 = backward)
//                step_state_t pulse generator states
//                is_motion()  true for states that emit step pulses
//  Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam logic FW = 1'b1;
    localparam logic BW = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCEL  = 3'd2,
        CRUISE = 3'd3,
        DECEL  = 3'd4
    } step_state_t;

    // States in which the period timer runs and STEP pulses are produced.
    function automatic logic is_motion(input step_state_t s);
        return (s == ACCEL) || (s == CRUISE) || (s == DECEL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_period_timer
//  Description : Step period counter for the step pulse generator. Counts
//                0..period-1 while the generator is in a motion state, flags
//                the last cycle of each period and produces the registered
//                STEP pulse (high for the first PULSE_W counts of a period).
//  Ports       : CLK        system clock
//                RSTn       asynchronous active-low reset
//                active     generator is in a motion state this cycle
//                active_nxt generator will be in a motion state next cycle
//                period     current step period in CLK cycles
//                step       registered STEP pulse
//                period_end last cycle of the current period
//                step_rise  STEP rises on the coming edge
//  Revision    : 1.0 - initial release
// ============================================================================
module step_period_timer #(
    parameter int PW      = 16,
    parameter int PULSE_W = 100
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          active,
    input  logic          active_nxt,
    input  logic [PW-1:0] period,
    output logic          step,
    output logic          period_end,
    output logic          step_rise
);

    localparam logic [PW-1:0] c_pulse_w = PW'(PULSE_W);
    localparam logic [PW-1:0] c_one     = PW'(1);

    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_nxt;

    assign period_end = active && (r_pcnt == (period - c_one));

    // The counter restarts at zero on entry to motion, at every period end
    // and whenever motion stops, so a new run always begins at count 0.
    always_comb begin
        w_pcnt_nxt = r_pcnt + c_one;
        if (!active || !active_nxt || period_end) begin
            w_pcnt_nxt = '0;
        end
    end

    // A count of zero in a motion state is exactly the first STEP-high cycle.
    assign step_rise = active_nxt && (w_pcnt_nxt == '0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pcnt <= '0;
            step   <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
            step   <= active_nxt && (w_pcnt_nxt < c_pulse_w);
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : step_pulse_gen
//  Description : Stepper driver front end. Turns the sequencer's en/dir
//                request into STEP/DIR/ENABLE with a trapezoidal speed
//                profile (linear period ramp on start and stop, cruise in
//                between). DIR is only ever changed from IDLE, so a direction
//                request mid-run decelerates to a stop and re-runs the setup.
//                Keeps a signed step position for readout.
//  Ports       : CLK       system clock
//                RSTn      asynchronous active-low reset
//                en        motion request (1 = move)
//                dir       requested direction (1 = FW, 0 = BW)
//                step      step pulse to driver
//                dir_out   latched direction to driver
//                drv_en    driver enable
//                at_speed  high while cruising
//                pos       signed step count, wraps modulo 2^POS_W
//  Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_gen
    import motor_pkg::*;
#(
    parameter int PW         = 16,
    parameter int PERIOD_MAX = 20000,
    parameter int PERIOD_MIN = 2000,
    parameter int RAMP_DEC   = 500,
    parameter int PULSE_W    = 100,
    parameter int DIR_SETUP  = 200,
    parameter int POS_W      = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             en,
    input  logic             dir,
    output logic             step,
    output logic             dir_out,
    output logic             drv_en,
    output logic             at_speed,
    output logic [POS_W-1:0] pos
);

    localparam int            c_pw1        = PW + 1;
    localparam logic [PW-1:0] c_period_max = PW'(PERIOD_MAX);
    localparam logic [PW-1:0] c_period_min = PW'(PERIOD_MIN);
    localparam logic [PW-1:0] c_setup_last = PW'(DIR_SETUP - 1);
    localparam logic [PW:0]   c_ramp_w     = c_pw1'(RAMP_DEC);
    localparam logic [PW:0]   c_max_w      = c_pw1'(PERIOD_MAX);
    localparam logic [PW:0]   c_min_w      = c_pw1'(PERIOD_MIN);

    step_state_t   r_state;
    step_state_t   w_state_nxt;
    logic [PW-1:0] r_period;
    logic [PW-1:0] w_period_nxt;
    logic [PW-1:0] r_tmr;
    logic [PW-1:0] w_tmr_nxt;
    logic          w_dir_nxt;

    logic          w_period_end;
    logic          w_step_rise;
    logic          w_go;
    logic [PW:0]   w_add;
    logic [PW:0]   w_sub;
    logic [PW-1:0] w_inc_sat;
    logic [PW-1:0] w_dec_sat;

    // Keep going only if the request still asks for motion in the latched
    // direction; anything else winds the speed back down.
    assign w_go = en && (dir == dir_out);

    // Ramp arithmetic carries one extra bit so a subtraction below zero shows
    // up in the MSB and an addition cannot wrap before saturation.
    assign w_add     = {1'b0, r_period} + c_ramp_w;
    assign w_sub     = {1'b0, r_period} - c_ramp_w;
    assign w_inc_sat = (w_add > c_max_w) ? c_period_max : w_add[PW-1:0];
    assign w_dec_sat = (w_sub[PW] || (w_sub < c_min_w)) ? c_period_min
                                                        : w_sub[PW-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_tmr_nxt    = r_tmr;
        w_dir_nxt    = dir_out;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_dir_nxt   = dir;
                    w_tmr_nxt   = '0;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (r_tmr == c_setup_last) begin
                    w_period_nxt = c_period_max;
                    w_state_nxt  = ACCEL;
                end else begin
                    w_tmr_nxt = r_tmr + PW'(1);
                end
            end
            ACCEL: begin
                if (w_period_end) begin
                    if (w_go) begin
                        w_period_nxt = w_dec_sat;
                        if (w_dec_sat == c_period_min) begin
                            w_state_nxt = CRUISE;
                        end
                    end else begin
                        w_period_nxt = w_inc_sat;
                        w_state_nxt  = DECEL;
                    end
                end
            end
            CRUISE: begin
                if (w_period_end && !w_go) begin
                    w_period_nxt = w_inc_sat;
                    w_state_nxt  = DECEL;
                end
            end
            DECEL: begin
                if (w_period_end) begin
                    if (w_go) begin
                        w_period_nxt = w_dec_sat;
                        w_state_nxt  = ACCEL;
                    end else if (w_add >= c_max_w) begin
                        // Slow enough to stop: the period that just ended was
                        // the last one, no further step is issued.
                        w_state_nxt = IDLE;
                    end else begin
                        w_period_nxt = w_add[PW-1:0];
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    step_period_timer #(
        .PW      (PW),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .active     (is_motion(r_state)),
        .active_nxt (is_motion(w_state_nxt)),
        .period     (r_period),
        .step       (step),
        .period_end (w_period_end),
        .step_rise  (w_step_rise)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= IDLE;
            r_period <= c_period_max;
            r_tmr    <= '0;
            dir_out  <= FW;
            drv_en   <= 1'b0;
            at_speed <= 1'b0;
            pos      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_period <= w_period_nxt;
            r_tmr    <= w_tmr_nxt;
            dir_out  <= w_dir_nxt;
            drv_en   <= (w_state_nxt != IDLE);
            at_speed <= (w_state_nxt == CRUISE);
            if (w_step_rise) begin
                pos <= (dir_out == FW) ? pos + POS_W'(1) : pos - POS_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_pulse_gen
//  Description : Self-checking bench for step_pulse_gen. A timestamp-based
//                reference model predicts every STEP rise (cycle, position,
//                direction, at_speed) into a queue; a monitor pops and
//                compares on each observed rise and also checks the level
//                outputs every cycle against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_gen;

    localparam int PMAX  = 20;
    localparam int PMIN  = 8;
    localparam int RAMP  = 4;
    localparam int PULSE = 2;
    localparam int SETUP = 5;

    // Model motion modes
    localparam int M_IDLE   = 0;
    localparam int M_SETUP  = 1;
    localparam int M_ACCEL  = 2;
    localparam int M_CRUISE = 3;
    localparam int M_DECEL  = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b1;
    logic        step;
    logic        dir_out;
    logic        drv_en;
    logic        at_speed;
    logic [15:0] pos;

    int total = 0;
    int bad   = 0;

    step_pulse_gen #(
        .PW         (16),
        .PERIOD_MAX (PMAX),
        .PERIOD_MIN (PMIN),
        .RAMP_DEC   (RAMP),
        .PULSE_W    (PULSE),
        .DIR_SETUP  (SETUP),
        .POS_W      (16)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .en       (en),
        .dir      (dir),
        .step     (step),
        .dir_out  (dir_out),
        .drv_en   (drv_en),
        .at_speed (at_speed),
        .pos      (pos)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works with absolute edge numbers. A step rise is an
    // event at an edge; the next period end is simply last rise + period.
    // ------------------------------------------------------------------
    typedef struct {
        int          edge_n;
        logic [15:0] pos;
        logic        dir;
        logic        at_spd;
    } rise_t;

    rise_t       q[$];
    int          cyc = 0;
    int          m_mode = M_IDLE;
    int          m_period = PMAX;
    int          m_next_end = 0;
    int          m_setup_end = 0;
    int          m_last_rise = -1000;
    logic        m_dir = 1'b1;
    logic [15:0] m_pos = 16'd0;

    task automatic model_rise();
        rise_t r;
        m_pos       = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
        m_last_rise = cyc;
        m_next_end  = cyc + m_period;
        r.edge_n    = cyc;
        r.pos       = m_pos;
        r.dir       = m_dir;
        r.at_spd    = (m_mode == M_CRUISE);
        q.push_back(r);
    endtask

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_mode      = M_IDLE;
            m_dir       = 1'b1;
            m_pos       = 16'd0;
            m_period    = PMAX;
            m_last_rise = -1000;
            q.delete();
        end else begin
            cyc++;
            if (m_mode == M_IDLE) begin
                if (en) begin
                    m_dir       = dir;
                    m_setup_end = cyc + SETUP;
                    m_mode      = M_SETUP;
                end
            end else if (m_mode == M_SETUP) begin
                if (cyc == m_setup_end) begin
                    m_period = PMAX;
                    m_mode   = M_ACCEL;
                    model_rise();
                end
            end else if (cyc == m_next_end) begin
                if (en && (dir == m_dir)) begin
                    if (m_mode != M_CRUISE) begin
                        m_period = (m_period - RAMP < PMIN) ? PMIN : m_period - RAMP;
                        m_mode = (m_mode == M_ACCEL && m_period == PMIN) ? M_CRUISE : M_ACCEL;
                    end
                    model_rise();
                end else if (m_mode == M_DECEL && m_period + RAMP >= PMAX) begin
                    m_mode = M_IDLE;
                end else begin
                    m_period = (m_period + RAMP > PMAX) ? PMAX : m_period + RAMP;
                    m_mode   = M_DECEL;
                    model_rise();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge.
    // ------------------------------------------------------------------
    logic prev_step = 1'b0;

    always @(negedge CLK) begin
        if (!RSTn) begin
            prev_step = 1'b0;
        end else begin
            check("step_level", step,
                  (m_mode >= M_ACCEL) && (cyc - m_last_rise < PULSE));
            check("drv_en", drv_en, m_mode != M_IDLE);
            check("at_speed", at_speed, m_mode == M_CRUISE);
            check("dir_out", dir_out, m_dir);
            check("pos", pos, m_pos);
            if (step && !prev_step) begin
                if (q.size() == 0) begin
                    check("unexpected_rise", 32'd1, 32'd0);
                end else begin
                    rise_t r;
                    r = q.pop_front();
                    check("rise_cycle", cyc, r.edge_n);
                    check("rise_pos", pos, r.pos);
                    check("rise_dir", dir_out, r.dir);
                    check("rise_at_speed", at_speed, r.at_spd);
                end
            end
            prev_step = step;
        end
    end

    // Waits for the next STEP rise, bounded.
    task automatic wait_rise(input string name);
        logic p;
        bit   found;
        p     = step;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLK);
            if (step && !p) found = 1'b1;
            p = step;
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        bit found;

        // Reset and idle
        cycles(3);
        RSTn = 1'b1;
        cycles(50);

        // Start forward, ramp to cruise
        en  = 1'b1;
        dir = 1'b1;
        cycles(120);

        // Stop from cruise mid-period
        wait_rise("stop");
        cycles(3);
        en = 1'b0;
        cycles(80);

        // Forward to cruise, then reverse
        en  = 1'b1;
        dir = 1'b1;
        cycles(100);
        dir = 1'b0;
        cycles(150);

        // Asynchronous reset during a STEP-high cycle
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLK);
            if (step) found = 1'b1;
        end
        if (!found) check("step_high_timeout", 32'd0, 32'd1);
        #2;
        RSTn = 1'b0;
        en   = 1'b0;
        dir  = 1'b1;
        #1;
        check("async_rst_step", step, 32'd0);
        check("async_rst_drv_en", drv_en, 32'd0);
        check("async_rst_pos", pos, 32'd0);
        check("async_rst_dir_out", dir_out, 32'd1);
        check("async_rst_at_speed", at_speed, 32'd0);
        cycles(2);
        RSTn = 1'b1;
        cycles(10);

        // Re-acceleration from DECEL
        en  = 1'b1;
        dir = 1'b1;
        cycles(100);
        wait_rise("reaccel_a");
        cycles(2);
        en = 1'b0;
        wait_rise("reaccel_b");
        wait_rise("reaccel_c");
        cycles(3);
        en = 1'b1;
        cycles(80);

        // Randomised request traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 59) == 0) dir = ~dir;
        end

        // Drain
        en = 1'b0;
        cycles(200);
        check("leftover_rises", q.size(), 32'd0);
        check("final_idle_drv_en", drv_en, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Downstream stage of the IR-sensor direction sequencer. Consumes its `en`/`dir` pair and drives the stepper driver's STEP/DIR/ENABLE pins.
- Generates a trapezoidal speed profile: linear period ramp-down on start, cruise, linear ramp-up on stop.
- Never changes DIR while stepping. A direction request mid-run forces a full decel and stop, then a fresh setup.
- Tracks signed step position for debug/readout.

Parameters:
PW, 16, width of period/timer counters
PERIOD_MAX, 20000, start/stop step period in CLK cycles (slowest speed)
PERIOD_MIN, 2000, cruise step period in CLK cycles (fastest speed)
RAMP_DEC, 500, period change per step during accel/decel
PULSE_W, 100, STEP high width in CLK cycles; must be < PERIOD_MIN
DIR_SETUP, 200, CLK cycles from DIR latch to first STEP rise
POS_W, 16, width of position counter

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
en  input  1  motion request from sequencer (1 = move)
dir  input  1  requested direction, 1 = FW, 0 = BW
step  output  1  step pulse to driver
dir_out  output  1  latched direction to driver
drv_en  output  1  driver enable
at_speed  output  1  high while in CRUISE
pos  output  POS_W  signed step count: +1 per FW step, -1 per BW step, wraps modulo 2^POS_W

Behaviour:
- Clock is CLK. Reset is RSTn, asynchronous, active-low.
- Reset values (all registers asynchronous, applied immediately even mid-pulse):
  - state = IDLE, step = 0, dir_out = 1 (FW), drv_en = 0, at_speed = 0, pos = 0.
  - period = PERIOD_MAX, pcnt = 0, tmr = 0.
- States: IDLE, SETUP, ACCEL, CRUISE, DECEL.
- IDLE:
  - drv_en = 0, step = 0.
  - On `en` = 1: dir_out <= dir, tmr <= 0, go to SETUP.
  - dir_out is written only here.
- SETUP:
  - drv_en = 1.
  - tmr counts 0..DIR_SETUP-1.
  - At DIR_SETUP-1: period <= PERIOD_MAX, pcnt <= 0, go to ACCEL.
  - `en` is ignored in SETUP; the run continues into ACCEL and is stopped there.
- Step timing (ACCEL/CRUISE/DECEL):
  - pcnt counts 0..period-1.
  - step = 1 while pcnt < PULSE_W (registered output); first rise is on the edge entering the motion state.
  - pos updates on the same edge that step rises.
- Period-end decision, taken at pcnt == period-1 with pcnt <= 0. Define `go` = en && (dir == dir_out).
  - ACCEL, go: period <= max(period-RAMP_DEC, PERIOD_MIN); when the new value == PERIOD_MIN, go to CRUISE.
  - CRUISE, go: hold period.
  - ACCEL or CRUISE, !go: go to DECEL, period <= period+RAMP_DEC.
  - DECEL, !go:
    - nxt = period+RAMP_DEC.
    - If nxt >= PERIOD_MAX: go to IDLE with no further step.
    - Else: period <= nxt.
  - DECEL, go: go to ACCEL, period <= max(period-RAMP_DEC, PERIOD_MIN).
  - `en`/`dir` are sampled only at period end; mid-period changes have no effect until then.
- Arithmetic and outputs:
  - Period add/sub computed PW+1 bits wide, then saturated to [PERIOD_MIN, PERIOD_MAX].
  - at_speed is registered: 1 exactly while state == CRUISE.
- Boundary cases:
  - If PERIOD_MAX-RAMP_DEC <= PERIOD_MIN, ACCEL reaches CRUISE after a single step.
  - A direction reversal always passes through DECEL → IDLE → SETUP; dir_out changes with step = 0 and ≥ DIR_SETUP cycles before the next step.
  - Returning to IDLE with `en` still 1 re-latches on the next cycle (one IDLE cycle minimum, drv_en low for that cycle).

Decomposition:
- Shared package (motor_pkg):
  - FW/BW constants.
  - step_state_t enum {IDLE, SETUP, ACCEL, CRUISE, DECEL} (reg [2:0]).
  - Shared with the sequencer's direction constants.
- One natural sub-module: step_period_timer, holding pcnt, the pulse compare and the period_end strobe. FSM and ramp arithmetic stay in the top.

Test Plan:
Bench parameters: PERIOD_MAX=20, PERIOD_MIN=8, RAMP_DEC=4, PULSE_W=2, DIR_SETUP=5.
1. Reset, en=0, 50 cycles → step=0, drv_en=0, dir_out=1, pos=0, at_speed=0 throughout.
2. en=1, dir=1 held → drv_en=1 one cycle after en; first step rise 5 cycles after SETUP entry; rise-to-rise spacings 20,16,12,8,8…; at_speed=1 from start of the first 8-cycle period; each pulse is 2 cycles high; pos increments per step.
3. From cruise, drop en mid-period → current period completes at 8; next periods 12, 16; then IDLE (no 20-cycle step); drv_en=0; exactly 2 steps after the period in which en fell.
4. Cruising FW, flip dir to 0 with en=1 → decel 12, 16; IDLE for 1 cycle; dir_out=0 set with step low; 5-cycle setup; periods 20,16,12,8; pos decrements.
5. Assert RSTn=0 during a step-high cycle → step, drv_en and pos go to 0 asynchronously, before the next CLK edge; after release, state IDLE.
6. During DECEL (period 12), re-assert en with the same dir before period end → state returns to ACCEL; next period 8; no IDLE visit; drv_en never drops.
